// File: rtl/eth_reset_sequencer_if.sv
// Soft-reset handshake and staged reset outputs of the Ethernet reset sequencer.
// The master side is the sequencer; the slave side is the controller/software requester.
interface eth_reset_sequencer_if;
    logic       soft_reset_req;
    logic       soft_reset_ack;
    logic       phy_reset_n;
    logic       mac_rx_reset;
    logic       mac_tx_reset;
    logic       ready;
    logic [2:0] state;

    modport master (
        input  soft_reset_req,
        output soft_reset_ack,
        output phy_reset_n,
        output mac_rx_reset,
        output mac_tx_reset,
        output ready,
        output state
    );

    modport slave (
        output soft_reset_req,
        input  soft_reset_ack,
        input  phy_reset_n,
        input  mac_rx_reset,
        input  mac_tx_reset,
        input  ready,
        input  state
    );
endinterface

// File: rtl/eth_reset_sequencer.sv
// Staged reset release for the Ethernet controller: PHY pin, settle window, MAC RX, MAC TX, ready.
// A soft-reset request accepted in READY replays the whole sequence.
module eth_reset_sequencer #(
    parameter int phy_hold_cycles_p    = 16,
    parameter int phy_settle_cycles_p  = 64,
    parameter int mac_stagger_cycles_p = 4
) (
    input  logic                         clk_i,
    input  logic                         async_reset_n_i,
    eth_reset_sequencer_if.master        rst_if
);

    localparam int max_ab_c = (phy_hold_cycles_p > phy_settle_cycles_p) ? phy_hold_cycles_p
                                                                         : phy_settle_cycles_p;
    localparam int max_c    = (max_ab_c > mac_stagger_cycles_p) ? max_ab_c : mac_stagger_cycles_p;
    localparam int cnt_w_c  = $clog2(max_c) + 1;

    localparam logic [cnt_w_c-1:0] hold_last_c    = cnt_w_c'(phy_hold_cycles_p - 1);
    localparam logic [cnt_w_c-1:0] settle_last_c  = cnt_w_c'(phy_settle_cycles_p - 1);
    localparam logic [cnt_w_c-1:0] stagger_last_c = cnt_w_c'(mac_stagger_cycles_p - 1);
    localparam logic [cnt_w_c-1:0] cnt_zero_c     = {cnt_w_c{1'b0}};
    localparam logic [cnt_w_c-1:0] cnt_one_c      = cnt_w_c'(1);

    if (phy_hold_cycles_p < 1) begin : g_bad_hold
        $error("phy_hold_cycles_p must be >= 1");
    end
    if (phy_settle_cycles_p < 1) begin : g_bad_settle
        $error("phy_settle_cycles_p must be >= 1");
    end
    if (mac_stagger_cycles_p < 1) begin : g_bad_stagger
        $error("mac_stagger_cycles_p must be >= 1");
    end

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_STAGGER = 3'd2,
        ST_READY   = 3'd3
    } state_e;

    state_e               state_q,        state_d;
    logic [cnt_w_c-1:0]   cnt_q,          cnt_d;
    logic                 phy_reset_n_q,  phy_reset_n_d;
    logic                 mac_rx_reset_q, mac_rx_reset_d;
    logic                 mac_tx_reset_q, mac_tx_reset_d;
    logic                 ready_q,        ready_d;
    logic                 ack_q,          ack_d;
    logic                 accept_s;

    // State, counter and output registers; async reset discards any partial count.
    always_ff @(posedge clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            state_q        <= ST_HOLD;
            cnt_q          <= cnt_zero_c;
            phy_reset_n_q  <= 1'b0;
            mac_rx_reset_q <= 1'b1;
            mac_tx_reset_q <= 1'b1;
            ready_q        <= 1'b0;
            ack_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            phy_reset_n_q  <= phy_reset_n_d;
            mac_rx_reset_q <= mac_rx_reset_d;
            mac_tx_reset_q <= mac_tx_reset_d;
            ready_q        <= ready_d;
            ack_q          <= ack_d;
        end
    end

    // Next-state and dwell counter; the request is only looked at in READY.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_s = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (cnt_q == hold_last_c) begin
                    state_d = ST_SETTLE;
                    cnt_d   = cnt_zero_c;
                end else begin
                    cnt_d   = cnt_q + cnt_one_c;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == settle_last_c) begin
                    state_d = ST_STAGGER;
                    cnt_d   = cnt_zero_c;
                end else begin
                    cnt_d   = cnt_q + cnt_one_c;
                end
            end
            ST_STAGGER: begin
                if (cnt_q == stagger_last_c) begin
                    state_d = ST_READY;
                    cnt_d   = cnt_zero_c;
                end else begin
                    cnt_d   = cnt_q + cnt_one_c;
                end
            end
            ST_READY: begin
                cnt_d = cnt_zero_c;
                if (rst_if.soft_reset_req) begin
                    state_d  = ST_HOLD;
                    accept_s = 1'b1;
                end else begin
                    state_d  = ST_READY;
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = cnt_zero_c;
            end
        endcase
    end

    // Output values decoded from the state being entered, so they change on the same edge.
    always_comb begin
        phy_reset_n_d  = 1'b0;
        mac_rx_reset_d = 1'b1;
        mac_tx_reset_d = 1'b1;
        ready_d        = 1'b0;
        ack_d          = accept_s;
        case (state_d)
            ST_HOLD: begin
                phy_reset_n_d  = 1'b0;
            end
            ST_SETTLE: begin
                phy_reset_n_d  = 1'b1;
            end
            ST_STAGGER: begin
                phy_reset_n_d  = 1'b1;
                mac_rx_reset_d = 1'b0;
            end
            ST_READY: begin
                phy_reset_n_d  = 1'b1;
                mac_rx_reset_d = 1'b0;
                mac_tx_reset_d = 1'b0;
                ready_d        = 1'b1;
            end
            default: begin
                phy_reset_n_d  = 1'b0;
            end
        endcase
    end

    assign rst_if.soft_reset_ack = ack_q;
    assign rst_if.phy_reset_n    = phy_reset_n_q;
    assign rst_if.mac_rx_reset   = mac_rx_reset_q;
    assign rst_if.mac_tx_reset   = mac_tx_reset_q;
    assign rst_if.ready          = ready_q;
    assign rst_if.state          = state_q;

endmodule

// File: tb/tb_eth_reset_sequencer.sv
// Bench for eth_reset_sequencer: default-parameter and minimum-parameter instances
// checked against a phase-count reference model, a timing table and corner-case sequences.
module tb_eth_reset_sequencer;

    localparam int H_D = 16, S_D = 64, T_D = 4;
    localparam int H_M = 1,  S_M = 1,  T_M = 1;
    localparam logic [7:0] RST_V = 8'b0000_0110;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   edge_cnt;
    int   p_d, p_m;
    logic ack_dm, ack_mm;
    int   ack_cnt;
    int   ready_cnt;

    eth_reset_sequencer_if if_d();
    eth_reset_sequencer_if if_m();

    eth_reset_sequencer #(
        .phy_hold_cycles_p(H_D), .phy_settle_cycles_p(S_D), .mac_stagger_cycles_p(T_D)
    ) dut_def (
        .clk_i(clk), .async_reset_n_i(rst_n), .rst_if(if_d)
    );

    eth_reset_sequencer #(
        .phy_hold_cycles_p(H_M), .phy_settle_cycles_p(S_M), .mac_stagger_cycles_p(T_M)
    ) dut_min (
        .clk_i(clk), .async_reset_n_i(rst_n), .rst_if(if_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         edge_n;
        logic [7:0] exp_def;
        logic [7:0] exp_min;
    } vec_t;

    // Output vector layout: {ack, state[2:0], ready, tx_reset, rx_reset, phy_reset_n}
    function automatic logic [7:0] out_d();
        return {if_d.soft_reset_ack, if_d.state, if_d.ready, if_d.mac_tx_reset,
                if_d.mac_rx_reset, if_d.phy_reset_n};
    endfunction

    function automatic logic [7:0] out_m();
        return {if_m.soft_reset_ack, if_m.state, if_m.ready, if_m.mac_tx_reset,
                if_m.mac_rx_reset, if_m.phy_reset_n};
    endfunction

    // p = edges elapsed since the sequence origin, saturating once all resets are released.
    function automatic logic [7:0] model_out(input int h, input int s, input int t,
                                             input int p, input logic ack);
        logic [2:0] st;
        st = (p < h) ? 3'd0 : (p < h + s) ? 3'd1 : (p < h + s + t) ? 3'd2 : 3'd3;
        return {ack, st, (p >= h + s + t), (p < h + s + t), (p < h + s), (p >= h)};
    endfunction

    task automatic model_edge(input int total, input logic req, inout int p, output logic ack);
        if (p >= total && req) begin
            p   = 0;
            ack = 1'b1;
        end else begin
            ack = 1'b0;
            if (p < total) p = p + 1;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (edge %0d): got %b expected %b", name, edge_cnt, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_order(input string name, input logic [7:0] o);
        logic bad;
        bad = (!o[2] && o[1]) || ((!o[1] || !o[2]) && !o[0]);
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL %s (edge %0d): got outputs %b, release order violated", name, edge_cnt, o);
        end
    endtask

    task automatic step(input logic rd, input logic rm);
        if_d.soft_reset_req = rd;
        if_m.soft_reset_req = rm;
        @(posedge clk);
        model_edge(H_D + S_D + T_D, rd, p_d, ack_dm);
        model_edge(H_M + S_M + T_M, rm, p_m, ack_mm);
        edge_cnt++;
        @(negedge clk);
        chk("model_def", out_d(), model_out(H_D, S_D, T_D, p_d, ack_dm));
        chk("model_min", out_m(), model_out(H_M, S_M, T_M, p_m, ack_mm));
        chk_order("order_def", out_d());
        chk_order("order_min", out_m());
        if (if_d.soft_reset_ack) ack_cnt++;
        if (if_d.ready) ready_cnt++;
    endtask

    task automatic run_to(input int target);
        while (edge_cnt < target) step(1'b0, 1'b0);
    endtask

    task automatic do_async_reset();
        #1 rst_n = 1'b0;
        #1;
        p_d = 0; p_m = 0; ack_dm = 1'b0; ack_mm = 1'b0;
        chk("async_def", out_d(), RST_V);
        chk("async_min", out_m(), RST_V);
        @(posedge clk);
        #1 rst_n = 1'b1;
        edge_cnt = 0;
    endtask

    vec_t tab[11];
    int   e0;

    initial begin
        n_tests = 0; n_fail = 0; edge_cnt = 0;
        p_d = 0; p_m = 0; ack_dm = 1'b0; ack_mm = 1'b0;
        ack_cnt = 0; ready_cnt = 0;
        rst_n = 1'b0;
        if_d.soft_reset_req = 1'b0;
        if_m.soft_reset_req = 1'b0;

        tab[0]  = '{0,  8'b0000_0110, 8'b0000_0110};
        tab[1]  = '{1,  8'b0000_0110, 8'b0001_0111};
        tab[2]  = '{2,  8'b0000_0110, 8'b0010_0101};
        tab[3]  = '{3,  8'b0000_0110, 8'b0011_1001};
        tab[4]  = '{15, 8'b0000_0110, 8'b0011_1001};
        tab[5]  = '{16, 8'b0001_0111, 8'b0011_1001};
        tab[6]  = '{79, 8'b0001_0111, 8'b0011_1001};
        tab[7]  = '{80, 8'b0010_0101, 8'b0011_1001};
        tab[8]  = '{83, 8'b0010_0101, 8'b0011_1001};
        tab[9]  = '{84, 8'b0011_1001, 8'b0011_1001};
        tab[10] = '{90, 8'b0011_1001, 8'b0011_1001};

        // Power-on
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("por_def", out_d(), RST_V);
        chk("por_min", out_m(), RST_V);
        @(posedge clk);
        #1 rst_n = 1'b1;
        edge_cnt = 0;

        for (int i = 0; i < 11; i++) begin
            run_to(tab[i].edge_n);
            chk("table_def", out_d(), tab[i].exp_def);
            chk("table_min", out_m(), tab[i].exp_min);
        end

        // Single-cycle soft reset from READY
        step(1'b1, 1'b0);
        e0 = edge_cnt;
        chk("soft_accept", out_d(), 8'b1000_0110);
        step(1'b0, 1'b0);
        chk("soft_ack_drop", out_d(), 8'b0000_0110);
        run_to(e0 + 15);
        chk("soft_hold_end", out_d(), 8'b0000_0110);
        run_to(e0 + 16);
        chk("soft_phy_rel", out_d(), 8'b0001_0111);
        run_to(e0 + 80);
        chk("soft_rx_rel", out_d(), 8'b0010_0101);
        run_to(e0 + 84);
        chk("soft_tx_rel", out_d(), 8'b0011_1001);

        // Request during SETTLE is ignored
        do_async_reset();
        run_to(16);
        chk("ign_phy_rel", out_d(), 8'b0001_0111);
        run_to(19);
        ack_cnt = 0;
        repeat (11) step(1'b1, 1'b0);
        run_to(80);
        chk("ign_rx_rel", out_d(), 8'b0010_0101);
        run_to(84);
        chk("ign_tx_rel", out_d(), 8'b0011_1001);
        chk_int("ign_no_ack", ack_cnt, 0);

        // Async reset in the middle of SETTLE restarts the full timing
        do_async_reset();
        run_to(40);
        do_async_reset();
        run_to(15);
        chk("mid_hold", out_d(), 8'b0000_0110);
        run_to(16);
        chk("mid_phy_rel", out_d(), 8'b0001_0111);
        run_to(80);
        chk("mid_rx_rel", out_d(), 8'b0010_0101);
        run_to(84);
        chk("mid_tx_rel", out_d(), 8'b0011_1001);

        // Held request: accepts at held edges 1, 86, 171, 256; ready seen after 85, 170, 255
        ack_cnt = 0;
        ready_cnt = 0;
        repeat (300) step(1'b1, 1'b0);
        chk_int("held_acks", ack_cnt, 4);
        chk_int("held_ready_cycles", ready_cnt, 3);
        step(1'b0, 1'b0);

        // Randomized requests and occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 399) == 0) do_async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
